// File: rtl/gsensor_spi_reader_if.sv
// Signal bundle between the ADXL345 SPI reader and the rest of the core:
// SPI pins, poll enable, and the X/Y/Z sample outputs.
interface gsensor_spi_reader_if;
  logic        enable;
  logic        spi_cs_;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [15:0] accel_x;
  logic [15:0] accel_y;
  logic [15:0] accel_z;
  logic        sample_valid;
  logic        ready;
  logic        busy;

  modport master (
    input  enable, spi_miso,
    output spi_cs_, spi_sclk, spi_mosi,
    output accel_x, accel_y, accel_z, sample_valid, ready, busy
  );

  modport slave (
    output enable, spi_miso,
    input  spi_cs_, spi_sclk, spi_mosi,
    input  accel_x, accel_y, accel_z, sample_valid, ready, busy
  );
endinterface

// File: rtl/gsensor_spi_reader.sv
// SPI mode-3 initiator for the ADXL345: writes DATA_FORMAT and POWER_CTL once,
// then polls the six data registers at a fixed rate and presents X/Y/Z samples.
module gsensor_spi_reader #(
  parameter int CLK_DIV     = 25,
  parameter int POLL_CYCLES = 500000
) (
  input logic                  clk,
  input logic                  rst,
  gsensor_spi_reader_if.master sensorIf
);

  localparam int DivW  = $clog2(CLK_DIV);
  localparam int PollW = $clog2(POLL_CYCLES + 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [PollW-1:0] PollLast = PollW'(POLL_CYCLES - 1);
  localparam logic [55:0] FmtFrame  = {16'h3108, 40'd0};
  localparam logic [55:0] PwrFrame  = {16'h2D08, 40'd0};
  localparam logic [55:0] ReadFrame = {8'hF2, 48'd0};

  typedef enum logic [1:0] {CFG_FMT, CFG_PWR, WAIT, READ} top_t;
  typedef enum logic [2:0] {PH_IDLE, PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD, PH_GAP} phase_t;

  top_t             top_q, top_d;
  phase_t           phase_q, phase_d;
  logic [DivW-1:0]  divCnt_q, divCnt_d;
  logic [5:0]       bitCnt_q, bitCnt_d;
  logic [PollW-1:0] pollCnt_q, pollCnt_d;
  logic [55:0]      txShift_q, txShift_d;
  logic [47:0]      rxShift_q, rxShift_d;
  logic [15:0]      accelX_q, accelX_d;
  logic [15:0]      accelY_q, accelY_d;
  logic [15:0]      accelZ_q, accelZ_d;
  logic             sampleValid_q, sampleValid_d;
  logic             ready_q, ready_d;
  logic             misoMeta_q, misoSync_q;
  logic             divDone;
  logic             lastBit;

  assign divDone = (divCnt_q == DivLast);
  assign lastBit = (bitCnt_q == ((top_q == READ) ? 6'd55 : 6'd15));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q         <= CFG_FMT;
      phase_q       <= PH_IDLE;
      divCnt_q      <= '0;
      bitCnt_q      <= '0;
      pollCnt_q     <= '0;
      txShift_q     <= '0;
      rxShift_q     <= '0;
      accelX_q      <= '0;
      accelY_q      <= '0;
      accelZ_q      <= '0;
      sampleValid_q <= 1'b0;
      ready_q       <= 1'b0;
      misoMeta_q    <= 1'b0;
      misoSync_q    <= 1'b0;
    end else begin
      top_q         <= top_d;
      phase_q       <= phase_d;
      divCnt_q      <= divCnt_d;
      bitCnt_q      <= bitCnt_d;
      pollCnt_q     <= pollCnt_d;
      txShift_q     <= txShift_d;
      rxShift_q     <= rxShift_d;
      accelX_q      <= accelX_d;
      accelY_q      <= accelY_d;
      accelZ_q      <= accelZ_d;
      sampleValid_q <= sampleValid_d;
      ready_q       <= ready_d;
      misoMeta_q    <= sensorIf.spi_miso;
      misoSync_q    <= misoMeta_q;
    end
  end

  always_comb begin
    top_d         = top_q;
    phase_d       = phase_q;
    divCnt_d      = divCnt_q;
    bitCnt_d      = bitCnt_q;
    pollCnt_d     = pollCnt_q;
    txShift_d     = txShift_q;
    rxShift_d     = rxShift_q;
    accelX_d      = accelX_q;
    accelY_d      = accelY_q;
    accelZ_d      = accelZ_q;
    sampleValid_d = 1'b0;
    ready_d       = ready_q;

    if (phase_q != PH_IDLE) begin
      divCnt_d = divDone ? '0 : divCnt_q + 1'b1;
    end

    unique case (phase_q)
      PH_IDLE: begin
        divCnt_d = '0;
        bitCnt_d = '0;
        unique case (top_q)
          CFG_FMT: begin
            phase_d   = PH_SETUP;
            txShift_d = FmtFrame;
          end
          CFG_PWR: begin
            phase_d   = PH_SETUP;
            txShift_d = PwrFrame;
          end
          WAIT: begin
            // Counter saturates at its last value so a late enable starts READ immediately.
            if (pollCnt_q != PollLast) begin
              pollCnt_d = pollCnt_q + 1'b1;
            end else if (sensorIf.enable) begin
              top_d     = READ;
              phase_d   = PH_SETUP;
              txShift_d = ReadFrame;
            end
          end
          default: ;
        endcase
      end
      PH_SETUP: if (divDone) phase_d = PH_LOW;
      PH_LOW:   if (divDone) phase_d = PH_HIGH;
      PH_HIGH: begin
        if (divDone) begin
          rxShift_d = {rxShift_q[46:0], misoSync_q};
          if (lastBit) begin
            phase_d = PH_HOLD;
          end else begin
            phase_d   = PH_LOW;
            bitCnt_d  = bitCnt_q + 1'b1;
            txShift_d = {txShift_q[54:0], 1'b0};
          end
        end
      end
      PH_HOLD: begin
        if (divDone) begin
          phase_d  = PH_GAP;
          bitCnt_d = '0;
        end
      end
      PH_GAP: begin
        // The gap is two divider periods; bitCnt_q[0] marks the second one.
        if (divDone) begin
          if (!bitCnt_q[0]) begin
            bitCnt_d = 6'd1;
          end else begin
            phase_d   = PH_IDLE;
            pollCnt_d = '0;
            unique case (top_q)
              CFG_FMT: top_d = CFG_PWR;
              CFG_PWR: begin
                top_d   = WAIT;
                ready_d = 1'b1;
              end
              READ: begin
                top_d         = WAIT;
                sampleValid_d = 1'b1;
                accelX_d      = {rxShift_q[39:32], rxShift_q[47:40]};
                accelY_d      = {rxShift_q[23:16], rxShift_q[31:24]};
                accelZ_d      = {rxShift_q[7:0],   rxShift_q[15:8]};
              end
              default: ;
            endcase
          end
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign sensorIf.spi_cs_      = !(phase_q inside {PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD});
  assign sensorIf.spi_sclk     = (phase_q != PH_LOW);
  assign sensorIf.spi_mosi     = (phase_q inside {PH_SETUP, PH_LOW, PH_HIGH}) ? txShift_q[55] : 1'b0;
  assign sensorIf.busy         = (phase_q != PH_IDLE);
  assign sensorIf.accel_x      = accelX_q;
  assign sensorIf.accel_y      = accelY_q;
  assign sensorIf.accel_z      = accelZ_q;
  assign sensorIf.sample_valid = sampleValid_q;
  assign sensorIf.ready        = ready_q;

endmodule
